// File: rtl/lsb_mem_port.sv
// lsb_mem_port: requester-side engine for the LSB port of the memory controller.
// It takes one decoded load/store at a time and drives the controller's request
// interface. The request is held stable until mem_ok arrives. Load data is
// sign- or zero-extended and returned with its ROB tag.
// Optional feature macro: IO_UART_GUARD_EN. When it is defined, a store to the
// IO region that is accepted while the UART buffer is full waits in IO_WAIT.
module lsb_mem_port #(
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_load,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [ROB_TAG_W-1:0] req_tag,
    output logic                 resp_valid,
    output logic [ROB_TAG_W-1:0] resp_tag,
    output logic [31:0]          resp_data,
    output logic                 mem_en,
    output logic                 mem_rw,
    output logic [2:0]           mem_width,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ok,
    input  logic                 io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IO_WAIT, BUSY, GAP} state_t;

    state_t                 state, state_nxt;
    logic                   is_load_q;
    logic [2:0]             funct3_q;
    logic [ROB_TAG_W-1:0]   tag_q;
    logic                   accept, start, stop, resp_fire, io_guard;

    // Extend raw controller data according to the load's size and signedness.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   extend = {{24{~f3[2] & d[7]}}, d[7:0]};
            2'b01:   extend = {{16{~f3[2] & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // funct3 size code to controller byte count; code 11 is treated as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] sz);
        case (sz)
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

`ifdef IO_UART_GUARD_EN
    // A store into the IO region must not reach the controller while the UART is full.
    assign io_guard = !req_is_load && (req_addr[17:16] == 2'b11) && io_buffer_full;
`else
    assign io_guard = 1'b0;
`endif

    // Acceptance is combinational. It is blocked in reset, when frozen, and on flush.
    assign req_ready = !rst && rdy && (state == IDLE) && !flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_nxt;
    end

    // Next-state logic. It also raises the control strobes that the datapath registers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        resp_fire = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (io_guard) begin
                        state_nxt = IO_WAIT;
                    end else begin
                        state_nxt = BUSY;
                        start     = 1'b1;
                    end
                end
            end
            IO_WAIT: begin
                if (flush && is_load_q) begin
                    state_nxt = IDLE;
                end else if (!io_buffer_full) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                end
            end
            BUSY: begin
                // A flushed load aborts and does not respond, even if ok arrives in the same cycle.
                if (flush && is_load_q) begin
                    state_nxt = GAP;
                    stop      = 1'b1;
                end else if (mem_ok) begin
                    state_nxt = GAP;
                    stop      = 1'b1;
                    resp_fire = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered request fields, controller drive and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_q  <= 1'b0;
            funct3_q   <= '0;
            tag_q      <= '0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_width  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else if (rdy) begin
            if (accept) begin
                is_load_q <= req_is_load;
                funct3_q  <= req_funct3;
                tag_q     <= req_tag;
                mem_rw    <= req_is_load;
                mem_width <= byte_count(req_funct3[1:0]);
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if (start)     mem_en <= 1'b1;
            else if (stop) mem_en <= 1'b0;
            resp_valid <= resp_fire;
            if (resp_fire) begin
                resp_tag  <= tag_q;
                resp_data <= is_load_q ? extend(funct3_q, mem_rdata) : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Scoreboard bench for lsb_mem_port. The driver plays both the load/store buffer
// and the memory controller. Expected responses are queued when the controller
// answers, and a monitor pops and compares them on every resp_valid.
module tb_lsb_mem_port;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, req_valid, req_is_load;
    logic        req_ready, resp_valid, mem_en, mem_rw, mem_ok, io_buffer_full;
    logic [2:0]  req_funct3, mem_width;
    logic [31:0] req_addr, req_wdata, resp_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  req_tag, resp_tag;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0]  exp_tag[$];
    logic [31:0] exp_data[$];
    bit prev_rv = 1'b0;

    lsb_mem_port #(.ROB_TAG_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_tag(req_tag), .resp_valid(resp_valid), .resp_tag(resp_tag),
        .resp_data(resp_data), .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ok(mem_ok), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: the architectural meaning of an RV32I load result.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] rd);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = rd & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = rd & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_width(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 32'd1 : (f3[1:0] == 2'b01) ? 32'd2 : 32'd4;
    endfunction

    // Monitor: every response must match the oldest expected entry and last one cycle.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            chk("resp_single_cycle", {31'd0, prev_rv}, 32'd0);
            if (exp_data.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_resp: got tag %h data %h, expected no response", resp_tag, resp_data);
            end else begin
                chk("resp_tag", {28'd0, resp_tag}, {28'd0, exp_tag.pop_front()});
                chk("resp_data", resp_data, exp_data.pop_front());
            end
        end
        prev_rv = !rst && resp_valid;
    end

    // Wait for ready (bounded), present one request, and return at the negedge after acceptance.
    task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a, wd, input logic [3:0] tg);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_load = ld; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_tag = tg;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // One full transaction. The controller answers lat cycles after mem_en rises.
    // If fl_at >= 0, flush is pulsed at that cycle. io_cyc > 0 holds the UART full at acceptance.
    task automatic run_req(input bit ld, input logic [2:0] f3, input logic [31:0] a, wd,
                           input logic [3:0] tg, input int lat, input int fl_at,
                           input logic [31:0] rd, input int io_cyc);
        bit done = 1'b0;
        int i = 0;
        if (io_cyc > 0) io_buffer_full = 1'b1;
        issue(ld, f3, a, wd, tg);
`ifdef IO_UART_GUARD_EN
        if (io_cyc > 0 && !ld && a[17:16] == 2'b11) begin
            for (int k = 0; k < io_cyc; k++) begin
                chk("io_wait_mem_en", {31'd0, mem_en}, 32'd0);
                if (k == io_cyc - 1) io_buffer_full = 1'b0;
                @(negedge clk);
            end
        end
`endif
        io_buffer_full = 1'b0;
        chk("mem_rw", {31'd0, mem_rw}, {31'd0, ld});
        chk("mem_width", {29'd0, mem_width}, ref_width(f3));
        while (!done) begin
            chk("mem_en_held", {31'd0, mem_en}, 32'd1);
            chk("mem_addr_held", mem_addr, a);
            chk("mem_wdata_held", mem_wdata, wd);
            if (i == fl_at) flush = 1'b1;
            if (i == lat) begin
                mem_ok = 1'b1;
                mem_rdata = rd;
                if (!(ld && i == fl_at)) begin
                    exp_tag.push_back(tg);
                    exp_data.push_back(ld ? ref_load(f3, rd) : 32'd0);
                end
            end
            @(negedge clk);
            if ((ld && i == fl_at) || i == lat) begin
                chk("mem_en_drop", {31'd0, mem_en}, 32'd0);
                chk("resp_at_k1", {31'd0, resp_valid}, {31'd0, (i == lat) && !(ld && i == fl_at)});
                chk("gap_not_ready", {31'd0, req_ready}, 32'd0);
                done = 1'b1;
            end
            flush = 1'b0;
            mem_ok = 1'b0;
            mem_rdata = $urandom;
            i++;
        end
        @(negedge clk);
        chk("ready_after_gap", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_load = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0; req_tag = '0;
        mem_rdata = '0; mem_ok = 1'b0; io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_outs", {resp_tag, mem_rw, mem_width}, 32'd0);
        chk("rst_data", resp_data | mem_addr | mem_wdata, 32'd0);
        rst = 1'b0;

        // Directed loads and stores.
        run_req(1, 3'b010, 32'h1000, 32'h0, 4'h3, 5, -1, 32'h8899AABB, 0);
        run_req(1, 3'b000, 32'h1004, 32'h0, 4'h4, 2, -1, 32'hDEADBE80, 0);
        run_req(1, 3'b100, 32'h1005, 32'h0, 4'h5, 1, -1, 32'hDEADBE80, 0);
        run_req(1, 3'b001, 32'h1006, 32'h0, 4'h6, 0, -1, 32'h00018001, 0);
        run_req(1, 3'b101, 32'h1006, 32'h0, 4'h7, 3, -1, 32'h00018001, 0);
        run_req(0, 3'b001, 32'h2002, 32'h12345678, 4'h8, 4, -1, 32'hFFFFFFFF, 0);
        // Flush two cycles into a load aborts it. The same flush on a store is ignored.
        run_req(1, 3'b010, 32'h3000, 32'h0, 4'h9, 6, 2, 32'h11111111, 0);
        run_req(0, 3'b010, 32'h3000, 32'hCAFEF00D, 4'hA, 6, 2, 32'h22222222, 0);
        // IO store while the UART buffer is full.
        run_req(0, 3'b000, 32'h30000, 32'h000000A5, 4'hB, 2, -1, 32'h0, 10);

        // A stray ok while idle must be ignored.
        @(negedge clk); mem_ok = 1'b1; @(negedge clk); mem_ok = 1'b0;

        // Reset during BUSY discards the request.
        issue(1, 3'b010, 32'h4000, 32'h0, 4'hC);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        #1 chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        run_req(1, 3'b000, 32'h4001, 32'h0, 4'hD, 2, -1, 32'h0000007F, 0);

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            bit ld;
            logic [2:0] f3;
            int lat, fl;
            ld  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            if (!ld) f3[2] = 1'b0;
            lat = $urandom_range(0, 6);
            fl  = ($urandom_range(0, 3) == 0 && lat > 0) ? $urandom_range(0, lat - 1) : -1;
            run_req(ld, f3, $urandom, $urandom, 4'($urandom), lat, fl, $urandom, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_data.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsb_mem_port.md
# lsb_mem_port

Requester-side engine for the load/store path of the memory controller. It accepts one decoded load or store at a time from the load/store buffer, drives the controller's LSB request interface, and holds the request stable until the controller returns its one-cycle ok pulse. It sign- or zero-extends load data and returns the result with its ROB tag. It sits between the load/store buffer and the memory controller, so it is the initiator end of the controller's LSB port.

## Interface
- ROB_TAG_W, default 4: width of the reorder-buffer tag.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable. Low freezes all state and outputs.
- flush  in  1  misprediction clear. Aborts a pending load; never aborts a store.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_is_load  in  1  1 = load, 0 = store.
- req_funct3  in  3  RV32I funct3. Bits [1:0]: 00 byte, 01 half, 10 word, 11 treated as word. Bit [2]: 1 = zero-extend (loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes significant.
- req_tag  in  ROB_TAG_W  ROB tag.
- resp_valid  out  1  one-cycle completion pulse.
- resp_tag  out  ROB_TAG_W  tag of the completed request.
- resp_data  out  32  extended load data; 0 for stores.
- mem_en  out  1  request enable to the controller.
- mem_rw  out  1  1 = read, 0 = write.
- mem_width  out  3  byte count: 1, 2 or 4.
- mem_addr  out  32  address to the controller.
- mem_wdata  out  32  write data to the controller.
- mem_rdata  in  32  read data from the controller. Byte 0 is in [7:0]; bytes above the width are stale.
- mem_ok  in  1  one-cycle done pulse from the controller.
- io_buffer_full  in  1  UART output buffer full.

## Operation
- States: IDLE, IO_WAIT, BUSY, GAP.
- req_ready = (state == IDLE) && !flush.
- IDLE
  - On req_valid && req_ready, latch every request field.
  - Go to BUSY, or to IO_WAIT when the guard condition holds (see Configuration).
- IO_WAIT
  - mem_en = 0.
  - Go to BUSY on the first cycle io_buffer_full = 0.
- BUSY
  - mem_en = 1. mem_rw, mem_width, mem_addr and mem_wdata are driven from the latched fields and held constant.
  - On mem_ok = 1: register resp_valid = 1, resp_tag and resp_data; drop mem_en; go to GAP.
- GAP
  - Exactly one cycle with mem_en = 0, so the controller returns to its stall state.
  - Then go to IDLE.
- Load extension:
  - Byte: resp_data = {24 × (funct3[2] ? 0 : rdata[7]), rdata[7:0]}.
  - Half: resp_data = {16 × (funct3[2] ? 0 : rdata[15]), rdata[15:0]}.
  - Word: resp_data = rdata.
- Flush
  - Load in BUSY: drop mem_en (aborts the controller), no response, go to GAP.
  - Load in IO_WAIT: go to IDLE.
  - Store in any state: flush is ignored; the store completes and responds.
  - IDLE: flush blocks acceptance that cycle.
- mem_ok while not in BUSY is ignored.
- Reset values, for every output:
  - req_ready = 0.
  - resp_valid = 0.
  - resp_tag = 0.
  - resp_data = 0.
  - mem_en = 0.
  - mem_rw = 0.
  - mem_width = 0.
  - mem_addr = 0.
  - mem_wdata = 0.
  - State = IDLE.
- Reset mid-transaction drops mem_en on the next edge and discards the request.

## Timing
- Request accepted at edge T. mem_en is high from T+1 (without the guard).
- mem_ok sampled high at edge K. resp_valid is high for exactly cycle K+1, and mem_en is low at K+1.
- GAP occupies cycle K+1. req_ready is high again at K+2.
- Maximum throughput: one request per (controller latency + 2) cycles.
- resp_valid never lasts more than one cycle. It fires at most once per accepted request.
- All outputs are registered except req_ready.

## Configuration
- IO_UART_GUARD_EN
  - Defined: a store with req_addr[17:16] == 2'b11 (IO region) that is accepted while io_buffer_full = 1 enters IO_WAIT instead of BUSY.
  - Not defined: io_buffer_full is ignored, IO_WAIT is unreachable, and every accepted request goes straight to BUSY.

## Test plan
- LW, addr 0x1000. Controller returns rdata 0x8899AABB and ok 5 cycles later → mem_width 4, mem_rw 1; one resp_valid with data 0x8899AABB and the request's tag.
- LB and LBU, rdata 0xDEADBE80 → resp_data 0xFFFFFF80 and 0x00000080 respectively. LH with rdata 0x00018001 → 0xFFFF8001.
- SH, addr 0x2002, wdata 0x12345678 → mem_rw 0, width 2, wdata held constant until ok; resp_data 0; mem_en low for one cycle after ok; req_ready high two cycles after ok.
- Flush two cycles into an LW → mem_en low next cycle, no resp_valid, req_ready high one cycle later. The same flush during an SW → store completes normally.
- With IO_UART_GUARD_EN: SB to 0x30000 while io_buffer_full = 1 for 10 cycles → mem_en stays low through those cycles and rises the cycle after full clears. Without the macro → mem_en rises at T+1.
- Reset asserted during BUSY → next cycle mem_en 0, resp_valid 0, req_ready 1 after reset deasserts; a later request completes normally.
